write_cmd_scheduler: RTL

- Queues write commands from the memory-controller side and issues them to the write manager.
- Per command it produces a single-cycle `o_wr_en` pulse plus stable burst-length and DRAM CRC configuration.
- Consecutive issues are spaced so each burst (including its optional CRC beat and a programmable gap) finishes before the next `o_wr_en`.
- It is the sequencing front-end that sits directly ahead of the write manager's `i_wr_en` / `i_burstlength` / `i_DRAM_crc_en` inputs.

---
 rtl/write_cmd_scheduler.sv | 72 +++++++
 1 files changed

// File: rtl/write_cmd_scheduler.sv
// write_cmd_scheduler: queues write commands and issues spaced one-cycle o_wr_en pulses to the write manager
module write_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [1:0]               i_cmd_bl,
  input  logic                     i_cmd_crc,
  input  logic                     i_phy_crc_mode,
  input  logic [GAP_W-1:0]         i_min_gap,
  output logic                     o_wr_en,
  output logic [1:0]               o_burstlength,
  output logic                     o_dram_crc_en,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL = LW'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SPACE = 1'b1;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [0:0] state;
  logic [5:0] cnt, period;
  logic [1:0] head_bl;
  logic head_crc, head_crc_eff, push, issue;
  assign o_cmd_ready = o_level != FULL;
  assign push = i_cmd_valid && o_cmd_ready;
  assign issue = (o_level != '0) && i_enable && (state == IDLE || cnt == '0);
  assign {head_bl, head_crc} = mem[rd_ptr];
  assign head_crc_eff = head_crc && i_phy_crc_mode;
  // BC8 and the reserved code both occupy a full BL16 slot; only BL32 is longer
  assign period = (head_bl == 2'b10 ? 6'd16 : 6'd8) + 6'(head_crc_eff) + 6'(i_min_gap);
  assign o_busy = state == SPACE || o_level != '0;
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {i_cmd_bl, i_cmd_crc};
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      o_level <= o_level + LW'(push) - LW'(issue);
    end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_wr_en <= 1'b0;
      o_burstlength <= 2'b00;
      o_dram_crc_en <= 1'b0;
    end else if (issue) begin
      state <= SPACE;
      cnt <= period - 6'd1;
      o_wr_en <= 1'b1;
      o_burstlength <= head_bl;
      o_dram_crc_en <= head_crc_eff;
    end else begin
      o_wr_en <= 1'b0;
      if (state == SPACE) begin
        if (cnt != '0) cnt <= cnt - 6'd1;
        else state <= IDLE;
      end
    end
endmodule
